stack_pointer_ctrl: RTL and testbench

//  Parametrised stack-pointer controller for the data-memory stack region; successor to the fixed 32-bit SP.

---
 rtl/stack_pointer_ctrl_pkg.sv | 22 ++
 rtl/sp_watermark_tracker.sv | 43 ++++
 rtl/stack_pointer_ctrl.sv | 132 +++++++++++++
 tb/tb_stack_pointer_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/stack_pointer_ctrl_pkg.sv
//==============================================================================
// Module  : stack_pointer_ctrl_pkg
// Brief   : Stack command encodings and default geometry for the stack SP.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package stack_pointer_ctrl_pkg;

    typedef enum logic [1:0] {
        stackPointerDef  = 2'b00,
        stackPointerPop  = 2'b01,
        stackPointerPush = 2'b10,
        stackPointerRepl = 2'b11
    } sp_cmd_e;

    localparam int unsigned C_DEFAULT_BASE_ADDR = 222;
    localparam int unsigned C_DEFAULT_DEPTH     = 34;

endpackage

`default_nettype wire

// File: rtl/sp_watermark_tracker.sv
//==============================================================================
// Module  : sp_watermark_tracker
// Brief   : Maximum stack occupancy since reset or the last error clear.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module sp_watermark_tracker #(
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [CNT_W-1:0] count_i,
    input  logic             clear_err_i,
    output logic [CNT_W-1:0] high_water_o
);

    logic [CNT_W-1:0] high_water_q;
    logic [CNT_W-1:0] high_water_d;

    // count_i is the occupancy about to be registered, so the mark moves on the same edge.
    always_comb begin
        high_water_d = high_water_q;
        if (clear_err_i) begin
            high_water_d = count_i;
        end else if (count_i > high_water_q) begin
            high_water_d = count_i;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            high_water_q <= '0;
        end else begin
            high_water_q <= high_water_d;
        end
    end

    assign high_water_o = high_water_q;

endmodule

`default_nettype wire

// File: rtl/stack_pointer_ctrl.sv
//==============================================================================
// Module  : stack_pointer_ctrl
// Brief   : Stack pointer / occupancy controller with push, pop, replace and
//           sticky overflow/underflow errors. Define STACK_WATERMARK_EN to add
//           the high_water output.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module stack_pointer_ctrl
    import stack_pointer_ctrl_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int BASE_ADDR = C_DEFAULT_BASE_ADDR,
    parameter int DEPTH     = C_DEFAULT_DEPTH,
    parameter int CNT_W     = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        newSP,
    input  logic              clear_err,
    output logic [ADDR_W-1:0] SP,
    output logic [ADDR_W-1:0] top_addr,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              op_reject,
`ifdef STACK_WATERMARK_EN
    output logic [CNT_W-1:0]  high_water,
`endif
    output logic              overflow_err,
    output logic              underflow_err
);

    localparam logic [ADDR_W-1:0] C_BASE  = ADDR_W'(BASE_ADDR);
    localparam logic [CNT_W-1:0]  C_DEPTH = CNT_W'(DEPTH);

    sp_cmd_e           cmd;
    logic [ADDR_W-1:0] sp_q, sp_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              reject_q, reject_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              ovf_set, unf_set;
    logic              empty_w, full_w;

    assign cmd     = sp_cmd_e'(newSP);
    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == C_DEPTH);

    always_comb begin
        sp_d     = sp_q;
        count_d  = count_q;
        ovf_set  = 1'b0;
        unf_set  = 1'b0;
        unique case (cmd)
            stackPointerDef: ;
            stackPointerPush: begin
                if (full_w) begin
                    ovf_set = 1'b1;
                end else begin
                    sp_d    = sp_q + ADDR_W'(1);
                    count_d = count_q + CNT_W'(1);
                end
            end
            stackPointerPop: begin
                if (empty_w) begin
                    unf_set = 1'b1;
                end else begin
                    sp_d    = sp_q - ADDR_W'(1);
                    count_d = count_q - CNT_W'(1);
                end
            end
            stackPointerRepl: begin
                // Data path overwrites the top slot; only the empty case matters here.
                unf_set = empty_w;
            end
            default: ;
        endcase
        reject_d = ovf_set | unf_set;
        // A fresh error outranks a simultaneous clear.
        ovf_d    = ovf_set | (ovf_q & ~clear_err);
        unf_d    = unf_set | (unf_q & ~clear_err);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sp_q     <= C_BASE;
            count_q  <= '0;
            reject_q <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            sp_q     <= sp_d;
            count_q  <= count_d;
            reject_q <= reject_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (sp_q == C_BASE + ADDR_W'(count_q))
                else $error("stack pointer out of step with occupancy");
        end
    end

    assign SP            = sp_q;
    assign top_addr      = empty_w ? C_BASE : (sp_q - ADDR_W'(1));
    assign count         = count_q;
    assign empty         = empty_w;
    assign full          = full_w;
    assign op_reject     = reject_q;
    assign overflow_err  = ovf_q;
    assign underflow_err = unf_q;

`ifdef STACK_WATERMARK_EN
    sp_watermark_tracker #(
        .CNT_W (CNT_W)
    ) u_watermark (
        .clock        (clock),
        .reset        (reset),
        .count_i      (count_d),
        .clear_err_i  (clear_err),
        .high_water_o (high_water)
    );
`endif

endmodule

`default_nettype wire

// File: tb/tb_stack_pointer_ctrl.sv
//==============================================================================
// Module  : tb_stack_pointer_ctrl
// Brief   : Self-checking bench for stack_pointer_ctrl against an occupancy model.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_stack_pointer_ctrl;

    localparam int ADDR_W = 32;
    localparam int BASE   = 222;
    localparam int DEPTH  = 34;
    localparam int CNT_W  = 6;

    localparam logic [1:0] C_DEF  = 2'b00;
    localparam logic [1:0] C_POP  = 2'b01;
    localparam logic [1:0] C_PUSH = 2'b10;
    localparam logic [1:0] C_REPL = 2'b11;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        newSP;
    logic              clear_err;
    logic [ADDR_W-1:0] SP, top_addr;
    logic [CNT_W-1:0]  count;
    logic              empty, full, op_reject, overflow_err, underflow_err;
`ifdef STACK_WATERMARK_EN
    logic [CNT_W-1:0]  high_water;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model: occupancy plus flags, everything else derived from it.
    int m_cnt, m_hw;
    bit m_ovf, m_unf, m_rej;

    always #5 clk = ~clk;

    stack_pointer_ctrl #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE),
        .DEPTH     (DEPTH),
        .CNT_W     (CNT_W)
    ) dut (
        .clock         (clk),
        .reset         (reset),
        .newSP         (newSP),
        .clear_err     (clear_err),
        .SP            (SP),
        .top_addr      (top_addr),
        .count         (count),
        .empty         (empty),
        .full          (full),
        .op_reject     (op_reject),
`ifdef STACK_WATERMARK_EN
        .high_water    (high_water),
`endif
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
    );

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_update(input logic [1:0] cmd, input bit clr, input bit rst);
        bit new_ovf, new_unf;
        new_ovf = 0;
        new_unf = 0;
        if (rst) begin
            m_cnt = 0; m_ovf = 0; m_unf = 0; m_rej = 0; m_hw = 0;
            return;
        end
        case (cmd)
            C_PUSH: if (m_cnt == DEPTH) new_ovf = 1; else m_cnt++;
            C_POP:  if (m_cnt == 0) new_unf = 1; else m_cnt--;
            C_REPL: if (m_cnt == 0) new_unf = 1;
            default: ;
        endcase
        m_rej = new_ovf | new_unf;
        if (clr) begin
            m_ovf = 0;
            m_unf = 0;
        end
        m_ovf = m_ovf | new_ovf;
        m_unf = m_unf | new_unf;
        if (clr) m_hw = m_cnt;
        else if (m_cnt > m_hw) m_hw = m_cnt;
    endtask

    task automatic check_all();
        check_eq("sp", longint'(SP), longint'(BASE + m_cnt));
        check_eq("top_addr", longint'(top_addr),
                 longint'((m_cnt == 0) ? BASE : BASE + m_cnt - 1));
        check_eq("count", longint'(count), longint'(m_cnt));
        check_eq("empty", longint'(empty), longint'(m_cnt == 0));
        check_eq("full", longint'(full), longint'(m_cnt == DEPTH));
        check_eq("op_reject", longint'(op_reject), longint'(m_rej));
        check_eq("overflow_err", longint'(overflow_err), longint'(m_ovf));
        check_eq("underflow_err", longint'(underflow_err), longint'(m_unf));
`ifdef STACK_WATERMARK_EN
        check_eq("high_water", longint'(high_water), longint'(m_hw));
`endif
    endtask

    task automatic step(input logic [1:0] cmd, input bit clr, input bit rst);
        @(negedge clk);
        newSP     = cmd;
        clear_err = clr;
        reset     = rst;
        @(posedge clk);
        model_update(cmd, clr, rst);
        #1;
        check_all();
    endtask

    task automatic repeat_cmd(input logic [1:0] cmd, input int n);
        for (int k = 0; k < n; k++) step(cmd, 1'b0, 1'b0);
    endtask

    initial begin
        int r;
        int bias;
        reset     = 1'b1;
        newSP     = C_DEF;
        clear_err = 1'b0;
        m_cnt = 0; m_ovf = 0; m_unf = 0; m_rej = 0; m_hw = 0;

        // Reset dominates a push command.
        step(C_PUSH, 1'b0, 1'b1);
        check_eq("reset_sp", longint'(SP), 222);
        check_eq("reset_empty", longint'(empty), 1);

        repeat_cmd(C_PUSH, 3);
        check_eq("t1_sp", longint'(SP), 225);
        check_eq("t1_count", longint'(count), 3);
        check_eq("t1_top", longint'(top_addr), 224);
        check_eq("t1_empty", longint'(empty), 0);
        step(C_PUSH, 1'b0, 1'b1);
        check_eq("t1_mid_reset_sp", longint'(SP), 222);
        check_eq("t1_mid_reset_count", longint'(count), 0);

        repeat_cmd(C_PUSH, 34);
        check_eq("t2_full", longint'(full), 1);
        check_eq("t2_sp", longint'(SP), 256);
        step(C_PUSH, 1'b0, 1'b0);
        check_eq("t2_sp_hold", longint'(SP), 256);
        check_eq("t2_reject", longint'(op_reject), 1);
        check_eq("t2_ovf", longint'(overflow_err), 1);
        step(C_DEF, 1'b0, 1'b0);
        check_eq("t2_reject_pulse", longint'(op_reject), 0);
        check_eq("t2_ovf_sticky", longint'(overflow_err), 1);

        step(C_DEF, 1'b0, 1'b1);
        step(C_POP, 1'b0, 1'b0);
        check_eq("t3_pop_sp", longint'(SP), 222);
        check_eq("t3_unf", longint'(underflow_err), 1);
        step(C_DEF, 1'b1, 1'b0);
        step(C_REPL, 1'b0, 1'b0);
        check_eq("t3_repl_unf", longint'(underflow_err), 1);
        check_eq("t3_repl_reject", longint'(op_reject), 1);
        step(C_DEF, 1'b1, 1'b0);
        check_eq("t3_clear_unf", longint'(underflow_err), 0);
        check_eq("t3_clear_ovf", longint'(overflow_err), 0);

        repeat_cmd(C_PUSH, 8);
        repeat_cmd(C_REPL, 5);
        check_eq("t4_sp", longint'(SP), 230);
        check_eq("t4_count", longint'(count), 8);
        repeat_cmd(C_PUSH, 26);
        step(C_REPL, 1'b0, 1'b0);
        check_eq("t4_full_repl_sp", longint'(SP), 256);
        check_eq("t4_full_repl_err", longint'(overflow_err | underflow_err), 0);

        step(C_PUSH, 1'b1, 1'b0);
        check_eq("t5_ovf_wins", longint'(overflow_err), 1);

        step(C_DEF, 1'b0, 1'b1);
        repeat_cmd(C_PUSH, 10);
        repeat_cmd(C_POP, 6);
        check_eq("t6_count", longint'(count), 4);
`ifdef STACK_WATERMARK_EN
        check_eq("t6_hw", longint'(high_water), 10);
        step(C_DEF, 1'b1, 1'b0);
        check_eq("t6_hw_clear", longint'(high_water), 4);
`endif

        // Randomized phases alternate between push-heavy and pop-heavy traffic.
        for (int i = 0; i < 2000; i++) begin
            logic [1:0] c;
            bias = ((i / 150) % 2 == 0) ? 55 : 15;
            r = int'($urandom_range(0, 99));
            if (r < bias) c = C_PUSH;
            else if (r < 70) c = C_POP;
            else if (r < 85) c = C_REPL;
            else c = C_DEF;
            step(c, ($urandom_range(0, 99) < 5), ($urandom_range(0, 299) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
